// File: rtl/gpu_line_pkg.sv
// Shared types and defaults for the GPU line-drawing write path.
package gpu_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_WRITE,
    ST_STEP,
    ST_DONE
  } line_wr_state_t;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int FB_ADDR_W    = 19;

  // |b - a| taking the 16-bit wrapped difference as two's complement;
  // the result needs 17 bits because |-32768| does not fit in 16.
  function automatic logic [16:0] abs_diff16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d = b - a;
    if (d[15]) abs_diff16 = {1'b0, ~d} + 17'd1;
    else       abs_diff16 = {1'b0, d};
  endfunction

endpackage

// File: rtl/line_addr_calc.sv
// Framebuffer word address y*SCREEN_W + x, truncated to ADDR_W bits.
// Purely combinational; shared with the rectangle fill path.
module line_addr_calc #(
  parameter int SCREEN_W = 640,
  parameter int ADDR_W   = 19
) (
  input  logic [15:0]       x,
  input  logic [15:0]       y,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [31:0] STRIDE = SCREEN_W;

  logic [31:0] full;

  // Wide product, then keep the low ADDR_W bits.
  always_comb begin
    full = ({16'd0, y} * STRIDE) + {16'd0, x};
    addr = full[ADDR_W-1:0];
  end

endmodule

// File: rtl/line_pixel_writer.sv
// Line pixel writer: loads the line stepper, walks it pixel by pixel and
// issues one framebuffer write per pixel over a valid/ack handshake.
// Optional build macro LINE_WRITER_CLIP_EN: off-screen pixels are skipped
// (no write) but still count toward the line length.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// LOAD   | calculate pulse, stepper takes the endpoints
// SETTLE | capture address of the stepper's current pixel
// WRITE  | wr_req held until wr_ack (or pixel clipped)
// STEP   | get_pixel pulse, stepper advances
// DONE   | done pulse, optional short_line
module line_pixel_writer
  import gpu_line_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int COLOR_W  = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [15:0]        cmd_x1,
  input  logic [15:0]        cmd_y1,
  input  logic [15:0]        cmd_x2,
  input  logic [15:0]        cmd_y2,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               calculate,
  output logic               get_pixel,
  output logic [15:0]        step_x1,
  output logic [15:0]        step_y1,
  output logic [15:0]        step_x2,
  output logic [15:0]        step_y2,
  input  logic [15:0]        x_i,
  input  logic [15:0]        y_i,
  input  logic               line_complete,
  output logic               wr_req,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  input  logic               wr_ack,
  output logic               busy,
  output logic               done,
  output logic               short_line
);

`ifdef LINE_WRITER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [31:0] SW32 = SCREEN_W;
  localparam logic [31:0] SH32 = SCREEN_H;

  line_wr_state_t state_q, state_d;

  logic [16:0]       len_q;
  logic [16:0]       pix_cnt_q;
  logic              short_q;
  logic [16:0]       dx, dy, span;
  logic [ADDR_W-1:0] pix_addr;
  logic              off_screen;
  logic              last_pix;
  logic              advance;

  line_addr_calc #(
    .SCREEN_W (SCREEN_W),
    .ADDR_W   (ADDR_W)
  ) u_addr (
    .x    (x_i),
    .y    (y_i),
    .addr (pix_addr)
  );

  // Line length in pixels and per-pixel status flags.
  always_comb begin
    dx         = abs_diff16(cmd_x1, cmd_x2);
    dy         = abs_diff16(cmd_y1, cmd_y2);
    span       = (dx > dy) ? dx : dy;
    off_screen = CLIP_EN && (({16'd0, x_i} >= SW32) || ({16'd0, y_i} >= SH32));
    last_pix   = (pix_cnt_q + 17'd1) == len_q;
  end

  // State register; reset aborts any line in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake strobes.
  always_comb begin
    state_d   = state_q;
    calculate = 1'b0;
    get_pixel = 1'b0;
    wr_req    = 1'b0;
    advance   = 1'b0;
    case (state_q)
      ST_IDLE:   if (cmd_valid) state_d = ST_LOAD;
      ST_LOAD: begin
        calculate = 1'b1;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_WRITE;
      ST_WRITE: begin
        wr_req  = !off_screen;
        advance = off_screen || wr_ack;
        if (advance) begin
          if (last_pix || line_complete) state_d = ST_DONE;
          else                           state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        get_pixel = 1'b1;
        state_d   = ST_SETTLE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Command latch, address capture and pixel bookkeeping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      step_x1   <= '0;
      step_y1   <= '0;
      step_x2   <= '0;
      step_y2   <= '0;
      wr_data   <= '0;
      wr_addr   <= '0;
      len_q     <= '0;
      pix_cnt_q <= '0;
      short_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && cmd_valid) begin
        step_x1   <= cmd_x1;
        step_y1   <= cmd_y1;
        step_x2   <= cmd_x2;
        step_y2   <= cmd_y2;
        wr_data   <= cmd_color;
        len_q     <= span + 17'd1;
        pix_cnt_q <= '0;
        short_q   <= 1'b0;
      end
      if (state_q == ST_SETTLE) wr_addr <= pix_addr;
      if (state_q == ST_WRITE && advance) begin
        pix_cnt_q <= pix_cnt_q + 17'd1;
        if (!last_pix && line_complete) short_q <= 1'b1;
      end
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign short_line = (state_q == ST_DONE) && short_q;

endmodule

// File: doc/line_pixel_writer.md
# line_pixel_writer

Consumes line-draw commands, drives the line stepper's `calculate`/`get_pixel` handshake, and turns every stepped pixel into a framebuffer write request. Sits between the GPU command decoder and the SRAM/framebuffer write port. One line in flight at a time, paced by a valid/ack memory handshake.

## Interface
- `SCREEN_W`, default 640: framebuffer width in pixels; address row stride.
- `SCREEN_H`, default 480: framebuffer height; used only by clipping.
- `ADDR_W`, default 19: framebuffer word-address width.
- `COLOR_W`, default 16: pixel data width.
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_x1`, `cmd_y1`, `cmd_x2`, `cmd_y2`  in  16 each  line endpoints, unsigned.
- `cmd_color`  in  COLOR_W  pixel colour.
- `calculate`  out  1  one-cycle pulse loading the stepper with the endpoints.
- `get_pixel`  out  1  one-cycle pulse advancing the stepper.
- `step_x1`, `step_y1`, `step_x2`, `step_y2`  out  16 each  latched endpoints to stepper.
- `x_i`, `y_i`  in  16 each  stepper current pixel.
- `line_complete`  in  1  stepper end-of-line flag.
- `wr_req`  out  1  write request, held until acked.
- `wr_addr`  out  ADDR_W  `y*SCREEN_W + x`, truncated to ADDR_W.
- `wr_data`  out  COLOR_W  latched colour.
- `wr_ack`  in  1  write accepted in any cycle `wr_req` is high.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse at line end.
- `short_line`  out  1  one-cycle pulse with `done` on early termination.

## Operation
- States: IDLE, LOAD, SETTLE, WRITE, STEP, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch endpoints and colour; compute `len` = max(|x2-x1|,|y2-y1|)+1 (17 bits, abs of 16-bit two's-complement difference); clear `pix_cnt`; go to LOAD.
- LOAD: `calculate`=1 → SETTLE.
- SETTLE: register `wr_addr` from `x_i`/`y_i` → WRITE.
- WRITE: `wr_req`=1 until `wr_ack`. On ack, `pix_cnt`++. If `pix_cnt`+1 == `len` → DONE; else if `line_complete`=1 → DONE with `short_line`; else → STEP.
- STEP: `get_pixel`=1 → SETTLE.
- DONE: `done`=1 → IDLE.
- `cmd_valid` while not IDLE is ignored; the command stays pending upstream.
- Zero-length line (`len`=1): exactly one write, no `get_pixel`.

## Timing
- Reset: state IDLE; `cmd_ready`=1; `calculate`, `get_pixel`, `wr_req`, `busy`, `done`, `short_line` = 0; `wr_addr`, `wr_data`, `step_*` = 0.
- Reset mid-line aborts immediately. `wr_req` drops asynchronously, and no `done` is issued.
- Accept at cycle 0 gives: `calculate` at cycle 1, first `wr_req` at cycle 3.
- With zero-wait ack, each additional pixel costs 3 cycles. N-pixel line: last ack at cycle 3N, `done` at 3N+1, `cmd_ready` at 3N+2.
- Ack wait states stretch WRITE only. `wr_addr` and `wr_data` are stable while `wr_req` is high.
- `calculate` and `get_pixel` are never high in the same cycle and never high while `wr_req` is high.

## Configuration
- `LINE_WRITER_CLIP_EN` defined: in WRITE, a pixel with `x_i` ≥ SCREEN_W or `y_i` ≥ SCREEN_H is off-screen.
  - No `wr_req` is issued for it.
  - It is treated as acked in that cycle and still counts toward `len`.
  - Negative coordinates wrap to large unsigned values and are clipped.
- Undefined: every pixel is written, and the address is simply truncated to ADDR_W.

## Structure
- Package `gpu_line_pkg` holds:
  - the state enum `line_wr_state_t`;
  - default constants `SCREEN_W_DEF`, `SCREEN_H_DEF`, `FB_ADDR_W`.
- Sub-module `line_addr_calc` is a combinational `y*SCREEN_W + x` with truncation. It is reused by the rectangle fill block.

## Test plan
- Line (0,0)→(3,0), colour 0xF800, zero-wait ack → writes at addresses 0,1,2,3; 4 `get_pixel`-free-after-last; `done` at cycle 13; `short_line`=0.
- Line (5,5)→(5,5) → one write to addr 3205, no `get_pixel`, `done` at cycle 4.
- Line (0,0)→(0,2) with `wr_ack` delayed 2 cycles each → addresses 0,640,1280; `wr_addr`/`wr_data` held through the waits.
- `cmd_valid` asserted mid-line → `cmd_ready`=0, ignored; accepted on the cycle after `done`.
- With clipping enabled, line (638,0)→(641,0) → writes 638,639 only; `done` after 4 counted pixels.
- `n_rst` low during WRITE → `wr_req`, `busy` = 0 at once; `cmd_ready`=1 after release.
